// File: rtl/fifo_access_arbiter_pkg.sv
// Shared constants for the FIFO access arbiter and the FIFO it commands.
package fifo_access_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10
  } opcode_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam int LEVEL_W = 5;

  // Round-robin slots in service order W0 -> W1 -> R
  localparam logic [1:0] SLOT_W0 = 2'd0;
  localparam logic [1:0] SLOT_W1 = 2'd1;
  localparam logic [1:0] SLOT_R  = 2'd2;

  function automatic logic [1:0] slot_of(input logic [2:0] onehot);
    logic [1:0] s;
    s = SLOT_W0;
    if (onehot[1]) s = SLOT_W1;
    if (onehot[2]) s = SLOT_R;
    return s;
  endfunction

endpackage

// File: rtl/fifo_access_arbiter_if.sv
// Bus between the arbiter, its two producers, its consumer and the FIFO.
interface fifo_access_arbiter_if #(parameter int DATA_W = 32);
  import fifo_access_arbiter_pkg::*;

  // Request/grant: a requester raises WrReqN/RdReq (with WrDataN stable) and
  // holds it until the one-cycle grant pulse; a request still high during
  // the grant cycle is a fresh request. RdValid qualifies RdData for a cycle.
  logic              WrReq0;
  logic              WrReq1;
  logic [DATA_W-1:0] WrData0;
  logic [DATA_W-1:0] WrData1;
  logic              RdReq;
  logic              Flush;
  logic [DATA_W-1:0] FifoDout;
  opcode_t           OpCode;
  logic [DATA_W-1:0] FifoDin;
  logic              WrGnt0;
  logic              WrGnt1;
  logic              RdGnt;
  logic              RdValid;
  logic [DATA_W-1:0] RdData;
  logic [4:0]        Level;
  logic              Full;
  logic              Empty;
  logic              Flushing;
  state_t            DbgState;

  modport master (
    input  WrReq0, WrReq1, WrData0, WrData1, RdReq, Flush, FifoDout,
    output OpCode, FifoDin, WrGnt0, WrGnt1, RdGnt, RdValid, RdData,
           Level, Full, Empty, Flushing, DbgState
  );

  modport slave (
    output WrReq0, WrReq1, WrData0, WrData1, RdReq, Flush, FifoDout,
    input  OpCode, FifoDin, WrGnt0, WrGnt1, RdGnt, RdValid, RdData,
           Level, Full, Empty, Flushing, DbgState
  );

endinterface

// File: rtl/fifo_access_arbiter_rr_pick3.sv
// Three-way round-robin pick: search starts at the slot after the last winner.
module rr_pick3
  import fifo_access_arbiter_pkg::*;
(
  input  logic [2:0] elig,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = 3'b000;
    case (last)
      SLOT_W0: begin
        if (elig[1])      gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
      end
      SLOT_W1: begin
        if (elig[2])      gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
      end
      default: begin
        if (elig[0])      gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Arbitrates two producers and one consumer onto a single FIFO command port,
// tracking occupancy and providing a flush mode that drains the FIFO.
module fifo_access_arbiter
  import fifo_access_arbiter_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  fifo_access_arbiter_if.master bus
);

  localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);

  state_t             state, state_n;
  logic [LEVEL_W-1:0] level, level_n;
  logic [1:0]         last, last_n;
  opcode_t            op_q, op_n;
  logic [DATA_W-1:0]  din_q, din_n;
  logic [2:0]         gnt_q, gnt_n;
  logic               rdvalid_q;
  logic [2:0]         elig, pick;

  // bit 0 = W0, bit 1 = W1, bit 2 = R
  assign elig = {bus.RdReq  && (level != '0),
                 bus.WrReq1 && (level < DEPTH_L),
                 bus.WrReq0 && (level < DEPTH_L)};

  rr_pick3 u_pick (
    .elig (elig),
    .last (last),
    .gnt  (pick)
  );

  always_comb begin
    state_n = state;
    level_n = level;
    last_n  = last;
    op_n    = OP_IDLE;
    din_n   = din_q;
    gnt_n   = 3'b000;
    case (state)
      ST_RUN: begin
        if (bus.Flush) begin
          state_n = ST_FLUSH;
        end else if (pick != 3'b000) begin
          gnt_n  = pick;
          last_n = slot_of(pick);
          if (pick[2]) begin
            op_n    = OP_READ;
            level_n = level - 1'b1;
          end else begin
            op_n    = OP_WRITE;
            din_n   = pick[0] ? bus.WrData0 : bus.WrData1;
            level_n = level + 1'b1;
          end
        end
      end
      default: begin
        // Drain without grants; leave as the last word is read out.
        if (level != '0) begin
          op_n    = OP_READ;
          level_n = level - 1'b1;
        end
        if (level <= LEVEL_W'(1)) state_n = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_RUN;
      level     <= '0;
      last      <= SLOT_R;
      op_q      <= OP_IDLE;
      din_q     <= '0;
      gnt_q     <= 3'b000;
      rdvalid_q <= 1'b0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      last      <= last_n;
      op_q      <= op_n;
      din_q     <= din_n;
      gnt_q     <= gnt_n;
      rdvalid_q <= (op_q == OP_READ);
    end
  end

  assign bus.OpCode   = op_q;
  assign bus.FifoDin  = din_q;
  assign bus.WrGnt0   = gnt_q[0];
  assign bus.WrGnt1   = gnt_q[1];
  assign bus.RdGnt    = gnt_q[2];
  assign bus.RdValid  = rdvalid_q;
  assign bus.RdData   = bus.FifoDout;
  assign bus.Level    = level;
  assign bus.Full     = (level == DEPTH_L);
  assign bus.Empty    = (level == '0);
  assign bus.Flushing = (state == ST_FLUSH);
  assign bus.DbgState = state;

  a_level_bound: assert property (@(posedge Clk) disable iff (Reset) level <= DEPTH_L);
  a_no_overflow: assert property (@(posedge Clk) disable iff (Reset)
                                  !(op_n == OP_WRITE && level == DEPTH_L));
  a_no_underflow: assert property (@(posedge Clk) disable iff (Reset)
                                   !(op_n == OP_READ && level == '0));
  a_one_grant: assert property (@(posedge Clk) disable iff (Reset) $onehot0(gnt_q));

endmodule
